// File: rtl/mmc1_pkg.sv
// Shared definitions for the MMC1 serial-load configuration sequencer:
// register-select codes, serial length and the sequencer state encoding.
package mmc1_pkg;

  localparam logic [1:0] REG_CONTROL = 2'b00;
  localparam logic [1:0] REG_CHR0    = 2'b01;
  localparam logic [1:0] REG_CHR1    = 2'b10;
  localparam logic [1:0] REG_PRG     = 2'b11;

  localparam int         SER_BITS = 5;
  localparam logic [2:0] BIT_LAST = 3'(SER_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_ALIGN = 3'd1,
    ST_BUS        = 3'd2,
    ST_GAP        = 3'd3,
    ST_FINISH     = 3'd4
  } seq_state_t;

  // Bit of the register value carried by serial bus cycle idx (LSB first).
  function automatic logic ser_bit(input logic [4:0] data, input logic [2:0] idx);
    logic b;
    if (idx < 3'd5) begin
      b = data[idx];
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/mmc1_m2_gen.sv
// CPU_M2 phase generator. Owns the free-running phase counter (one bus
// cycle = 2*M2_DIV clocks, M2 high in the second half) and tells the
// sequencer when the counter is about to wrap and whether the count loaded
// on the next edge lies inside the nCPU_ROMSEL low window.
import mmc1_pkg::*;

module mmc1_m2_gen #(
  parameter int M2_DIV     = 4,
  parameter int ROMSEL_DLY = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic m2,
  output logic wrap,
  output logic romsel_window
);

  localparam int CW = $clog2(2 * M2_DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(2 * M2_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] M2_LO    = CW'(M2_DIV);
  localparam logic [CW-1:0] WIN_LO   = CW'(M2_DIV + ROMSEL_DLY);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          m2_r;

  // Next phase count: wraps to zero after the last M2-high clock.
  always_comb begin
    cnt_s = CNT_ZERO;
    if (cnt_r == CNT_LAST) begin
      cnt_s = CNT_ZERO;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // Phase counter and registered M2, kept in lock-step with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
      m2_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      m2_r  <= (cnt_s >= M2_LO);
    end
  end

  assign m2            = m2_r;
  assign wrap          = (cnt_r == CNT_LAST);
  assign romsel_window = (cnt_s >= WIN_LO);

endmodule

// File: rtl/mmc1_cfg_sequencer.sv
// MMC1 serial-load configuration sequencer. Turns one host request into
// either five LSB-first single-bit writes or one D7=1 shift-register reset
// write on the mapper CPU bus, every output registered on CLK.
// Optional build macro MMC1_SEQ_GAP_EN: inserts one idle bus cycle between
// successive serial bits of a data write (9 bus cycles per write).
import mmc1_pkg::*;

module mmc1_cfg_sequencer #(
  parameter int M2_DIV     = 4,
  parameter int ROMSEL_DLY = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RESET,
  input  logic [1:0] REQ_REG,
  input  logic [4:0] REQ_DATA,
  output logic       DONE,
  output logic       CPU_M2,
  output logic       nCPU_ROMSEL,
  output logic       nCPU_RW,
  output logic       CPU_A14,
  output logic       CPU_A13,
  output logic       CPU_D7,
  output logic       CPU_D0
);

  seq_state_t state_r, state_s;
  logic [2:0] bit_r, bit_s;
  logic       accept_s;

  logic       req_reset_r;
  logic [1:0] req_reg_r;
  logic [4:0] req_data_r;

  logic wrap_s;
  logic romsel_win_s;

  logic ready_s, done_s, romsel_s, rw_s, a14_s, a13_s, d7_s, d0_s;
  logic ready_r, done_r, romsel_r, rw_r, a14_r, a13_r, d7_r, d0_r;

  mmc1_m2_gen #(
    .M2_DIV     (M2_DIV),
    .ROMSEL_DLY (ROMSEL_DLY)
  ) u_m2_gen (
    .clk           (CLK),
    .rst_n         (nRST),
    .m2            (CPU_M2),
    .wrap          (wrap_s),
    .romsel_window (romsel_win_s)
  );

  // Next state, bit index and request acceptance; bus cycles change on wrap.
  always_comb begin
    state_s  = state_r;
    bit_s    = bit_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_FINISH: begin
        if (REQ_VALID) begin
          accept_s = 1'b1;
          state_s  = ST_WAIT_ALIGN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_WAIT_ALIGN: begin
        if (wrap_s) begin
          state_s = ST_BUS;
          bit_s   = 3'd0;
        end else begin
          state_s = ST_WAIT_ALIGN;
        end
      end
      ST_BUS: begin
        if (wrap_s) begin
          if (req_reset_r || (bit_r == BIT_LAST)) begin
            state_s = ST_FINISH;
          end else begin
`ifdef MMC1_SEQ_GAP_EN
            state_s = ST_GAP;
`else
            state_s = ST_BUS;
            bit_s   = bit_r + 3'd1;
`endif
          end
        end else begin
          state_s = ST_BUS;
        end
      end
      ST_GAP: begin
        if (wrap_s) begin
          state_s = ST_BUS;
          bit_s   = bit_r + 3'd1;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        bit_s   = 3'd0;
      end
    endcase
  end

  // Bus drive for the state and phase being entered, so the registers
  // below present them aligned with the M2 phase.
  always_comb begin
    ready_s  = (state_s == ST_IDLE) || (state_s == ST_FINISH);
    done_s   = (state_s == ST_FINISH);
    romsel_s = 1'b1;
    rw_s     = 1'b1;
    a14_s    = 1'b0;
    a13_s    = 1'b0;
    d7_s     = 1'b0;
    d0_s     = 1'b0;
    if (state_s == ST_BUS) begin
      rw_s     = 1'b0;
      romsel_s = ~romsel_win_s;
      if (req_reset_r) begin
        d7_s  = 1'b1;
      end else begin
        a14_s = req_reg_r[1];
        a13_s = req_reg_r[0];
        d0_s  = ser_bit(req_data_r, bit_s);
      end
    end else begin
      romsel_s = 1'b1;
    end
  end

  // Sequencer state, latched request and registered bus outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= ST_IDLE;
      bit_r       <= 3'd0;
      req_reset_r <= 1'b0;
      req_reg_r   <= 2'b00;
      req_data_r  <= 5'b00000;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      romsel_r    <= 1'b1;
      rw_r        <= 1'b1;
      a14_r       <= 1'b0;
      a13_r       <= 1'b0;
      d7_r        <= 1'b0;
      d0_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      bit_r   <= bit_s;
      if (accept_s) begin
        req_reset_r <= REQ_RESET;
        req_reg_r   <= REQ_REG;
        req_data_r  <= REQ_DATA;
      end
      ready_r  <= ready_s;
      done_r   <= done_s;
      romsel_r <= romsel_s;
      rw_r     <= rw_s;
      a14_r    <= a14_s;
      a13_r    <= a13_s;
      d7_r     <= d7_s;
      d0_r     <= d0_s;
    end
  end

  assign REQ_READY   = ready_r;
  assign DONE        = done_r;
  assign nCPU_ROMSEL = romsel_r;
  assign nCPU_RW     = rw_r;
  assign CPU_A14     = a14_r;
  assign CPU_A13     = a13_r;
  assign CPU_D7      = d7_r;
  assign CPU_D0      = d0_r;

endmodule

// File: tb/tb_mmc1_cfg_sequencer.sv
// Scoreboard bench for mmc1_cfg_sequencer: requests push expected bus writes
// and DONE latencies; a monitor pops them at each nCPU_ROMSEL fall / DONE
// and also feeds a small MMC1 serial-load mapper model.
module tb_mmc1_cfg_sequencer;

`ifdef MMC1_SEQ_GAP_EN
  localparam int STEP   = 16;  // bus cycle + gap cycle between serial bits
  localparam int WR_LAT = 67;  // 9 bus cycles (72 clk) minus 5 to first fall
`else
  localparam int STEP   = 8;
  localparam int WR_LAT = 35;  // 5 bus cycles (40 clk) minus 5 to first fall
`endif
  localparam int RST_LAT = 3;  // 1 bus cycle (8 clk) minus 5 to first fall

  logic       CLK = 1'b0;
  logic       nRST;
  logic       REQ_VALID, REQ_RESET;
  logic [1:0] REQ_REG;
  logic [4:0] REQ_DATA;
  logic       REQ_READY, DONE, CPU_M2, nCPU_ROMSEL, nCPU_RW;
  logic       CPU_A14, CPU_A13, CPU_D7, CPU_D0;

  typedef struct {
    logic [3:0] bus;   // {A14,A13,D7,D0}
    int         gap;   // clocks since previous fall, 0 = first bit
  } bus_exp_t;

  bus_exp_t bus_q[$];
  int       done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int falls    = 0;
  int first_fall = 0;
  int last_fall  = 0;
  int chg_cyc    = 0;

  logic [4:0] mreg [4];
  logic [4:0] msr;
  int         mcnt;

  mmc1_cfg_sequencer dut (
    .CLK(CLK), .nRST(nRST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_RESET(REQ_RESET), .REQ_REG(REQ_REG), .REQ_DATA(REQ_DATA), .DONE(DONE),
    .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
    .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D7(CPU_D7), .CPU_D0(CPU_D0)
  );

  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: scoreboard pops and mapper model, sampled on the falling edge.
  initial begin
    logic       prev_romsel;
    logic [4:0] vec, prev_vec;
    bus_exp_t   e;
    int         lat;
    prev_romsel = 1'b1;
    prev_vec    = 5'b00001;
    mreg[0] = 5'd0; mreg[1] = 5'd0; mreg[2] = 5'd0; mreg[3] = 5'd0;
    msr  = 5'd0;
    mcnt = 0;
    forever begin
      @(negedge CLK);
      vec = {CPU_A14, CPU_A13, CPU_D7, CPU_D0, nCPU_RW};
      if (vec != prev_vec) chg_cyc = cyc;
      prev_vec = vec;
      if (nRST && prev_romsel && !nCPU_ROMSEL) begin
        falls = falls + 1;
        if (bus_q.size() == 0) begin
          check("unexpected_fall", 32'd1, 32'd0);
        end else begin
          e = bus_q.pop_front();
          check("bus_a14_a13_d7_d0", {28'd0, CPU_A14, CPU_A13, CPU_D7, CPU_D0}, {28'd0, e.bus});
          check("fall_m2_rw", {30'd0, CPU_M2, nCPU_RW}, 32'd2);
          n_checks = n_checks + 1;
          if (cyc - chg_cyc < 5) begin
            n_fail = n_fail + 1;
            $display("FAIL setup actual=%0d required>=5 (cycle %0d)", cyc - chg_cyc, cyc);
          end
          if (e.gap == 0) first_fall = cyc;
          else check("fall_spacing", cyc - last_fall, e.gap);
          last_fall = cyc;
        end
        if (!nCPU_RW) begin
          if (CPU_D7) begin
            msr = 5'd0;
            mcnt = 0;
            mreg[0] = mreg[0] | 5'b01100;
          end else begin
            msr  = {CPU_D0, msr[4:1]};
            mcnt = mcnt + 1;
            if (mcnt == 5) begin
              mreg[{CPU_A14, CPU_A13}] = msr;
              msr  = 5'd0;
              mcnt = 0;
            end
          end
        end
      end
      if (nRST && DONE) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          lat = done_q.pop_front();
          check("done_latency", cyc - first_fall, lat);
          check("ready_with_done", {31'd0, REQ_READY}, 32'd1);
        end
      end
      prev_romsel = nCPU_ROMSEL;
    end
  end

  task automatic send(input logic rst_req, input logic [1:0] r, input logic [4:0] d,
                      input bit hold, output logic done_seen);
    bit accepted;
    bus_exp_t e;
    accepted  = 1'b0;
    done_seen = 1'b0;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_RESET = rst_req;
    REQ_REG   = r;
    REQ_DATA  = d;
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (REQ_READY) begin
        done_seen = DONE;
        if (rst_req) begin
          e.bus = 4'b0010; e.gap = 0;
          bus_q.push_back(e);
          done_q.push_back(RST_LAT);
        end else begin
          for (int b = 0; b < 5; b++) begin
            e.bus = {r, 1'b0, d[b]};
            e.gap = (b == 0) ? 0 : STEP;
            bus_q.push_back(e);
          end
          done_q.push_back(WR_LAT);
        end
        accepted = 1'b1;
        @(posedge CLK);
      end else begin
        @(negedge CLK);
      end
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) begin
      #1 REQ_VALID = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge CLK);
      idle = (bus_q.size() == 0) && (done_q.size() == 0);
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {24'd0, CPU_M2, nCPU_ROMSEL, nCPU_RW, REQ_READY, DONE, CPU_A14, CPU_A13, CPU_D7 | CPU_D0},
          32'b0111_0000);
  endtask

  initial begin
    logic ds;
    int   t0;
    bit   got;
    nRST = 1'b0; REQ_VALID = 1'b0; REQ_RESET = 1'b0; REQ_REG = 2'b00; REQ_DATA = 5'd0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_hold");
    nRST = 1'b1;
    #1 check_reset_outputs("reset_release");

    // M2 period: two successive rising edges of CPU_M2.
    t0 = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge CLK); got = CPU_M2; end
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge CLK); got = !CPU_M2; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge CLK); got = CPU_M2; end
    check("m2_period", cyc - t0, 8);

    // Control write.
    send(1'b0, 2'b00, 5'b01110, 1'b0, ds);
    wait_idle();
    check("model_control", {27'd0, mreg[0]}, 32'b01110);

    // Shift-register reset request.
    send(1'b1, 2'b11, 5'b10101, 1'b0, ds);
    wait_idle();
    check("model_prg_mode", {30'd0, mreg[0][3:2]}, 32'b11);

    // Back-to-back with VALID held.
    send(1'b0, 2'b11, 5'b10011, 1'b1, ds);
    send(1'b0, 2'b10, 5'b00001, 1'b0, ds);
    check("b2b_accept_on_done", {31'd0, ds}, 32'd1);
    wait_idle();
    check("model_prg", {27'd0, mreg[3]}, 32'b10011);
    check("model_chr1", {27'd0, mreg[2]}, 32'b00001);

    // Reset in the middle of a CHR0 write.
    t0 = falls;
    send(1'b0, 2'b01, 5'b11011, 1'b0, ds);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge CLK); got = (falls >= t0 + 2); end
    if (!got) check("abort_wait", 32'd0, 32'd1);
    repeat (2) @(negedge CLK);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("async_abort");
    bus_q.delete();
    done_q.delete();
    @(negedge CLK);
    #2 nRST = 1'b1;
    send(1'b1, 2'b00, 5'b00000, 1'b0, ds);
    send(1'b0, 2'b01, 5'b10101, 1'b0, ds);
    wait_idle();
    check("model_chr0_after_abort", {27'd0, mreg[1]}, 32'b10101);

    // VALID pulsed with other data while busy.
    send(1'b0, 2'b01, 5'b00110, 1'b0, ds);
    repeat (12) @(negedge CLK);
    REQ_VALID = 1'b1; REQ_REG = 2'b11; REQ_DATA = 5'b11111;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    wait_idle();
    check("model_chr0_busy", {27'd0, mreg[1]}, 32'b00110);
    check("model_prg_untouched", {27'd0, mreg[3]}, 32'b10011);
    check_reset_outputs("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
